// File: rtl/pc_queue_ctrl.sv
// Two-entry PC queue (front/back) stepped once per accepted fetch, with delay-slot nullify and imem handshake.
// Latency: PC, nullify and redirect updates are registered and visible one cycle after the advancing edge.
// Backpressure: imem_ready=0 parks the FSM in WAIT and stall_in=1 freezes the queue; in both cases a taken branch is captured as a pending redirect.
module pc_queue_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                INC      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] target_pc,
  input  logic              nullify_req,
  input  logic              imem_ready,
  output logic              imem_req,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] pc_front,
  output logic [ADDR_W-1:0] pc_back,
  output logic              nullify_out,
  output logic              redirect_pend
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INC);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_front_q, pc_front_d;
  logic [ADDR_W-1:0] pc_back_q, pc_back_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              pend_q, pend_d;
  logic              nullify_q, nullify_d;
  logic              adv;
  logic              taken;
  logic [ADDR_W-1:0] tgt;

  // Next-state, queue advance and redirect capture; defaults hold every register.
  always_comb begin
    state_d    = state_q;
    pc_front_d = pc_front_q;
    pc_back_d  = pc_back_q;
    pend_tgt_d = pend_tgt_q;
    pend_d     = pend_q;
    nullify_d  = nullify_q;
    imem_req   = 1'b0;

    case (state_q)
      BOOT: begin
        imem_req = 1'b0;
        state_d  = RUN;
      end
      RUN: begin
        imem_req = 1'b1;
        if (!imem_ready) state_d = WAIT;
      end
      WAIT: begin
        imem_req = 1'b1;
        if (imem_ready) state_d = RUN;
      end
      default: begin
        imem_req = 1'b0;
        state_d  = BOOT;
      end
    endcase

    // Inputs only matter once the fetch side is live (not in BOOT).
    adv   = (state_q == RUN || state_q == WAIT) && imem_ready && !stall_in;
    // A live branch always beats an older captured one.
    taken = branch_taken | pend_q;
    tgt   = branch_taken ? target_pc : pend_tgt_q;

    if (adv) begin
      pc_front_d = pc_back_q;
      pc_back_d  = taken ? tgt : pc_back_q + STEP;
      pend_d     = 1'b0;
      nullify_d  = nullify_req;
    end else if (state_q != BOOT && branch_taken) begin
      // Queue is frozen: remember the newest target until the next advance.
      pend_d     = 1'b1;
      pend_tgt_d = target_pc;
    end
  end

  // State and queue registers; reset clears any in-flight request or redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_front_q <= RESET_PC;
      pc_back_q  <= RESET_PC + STEP;
      pend_tgt_q <= '0;
      pend_q     <= 1'b0;
      nullify_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_front_q <= pc_front_d;
      pc_back_q  <= pc_back_d;
      pend_tgt_q <= pend_tgt_d;
      pend_q     <= pend_d;
      nullify_q  <= nullify_d;
    end
  end

  assign fetch_addr    = pc_front_q;
  assign pc_front      = pc_front_q;
  assign pc_back       = pc_back_q;
  assign nullify_out   = nullify_q;
  assign redirect_pend = pend_q;

endmodule

// File: tb/tb_pc_queue_ctrl.sv
// Bench for pc_queue_ctrl: directed scenarios then randomized traffic against a behavioural model.
// Inputs change on the falling edge; outputs are compared on the falling edge after each rising edge.
// Model tracks only "fetch live" plus the PC queue, not the DUT's FSM encoding.
module tb_pc_queue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall_in, branch_taken, nullify_req, imem_ready;
  logic [7:0] target_pc;
  logic       imem_req, nullify_out, redirect_pend;
  logic [7:0] fetch_addr, pc_front, pc_back;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit       m_live;
  int       m_front, m_back, m_ptgt;
  bit       m_pend, m_nul;

  always #5 clk = ~clk;

  pc_queue_ctrl #(.ADDR_W(8), .RESET_PC(8'h00), .INC(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .branch_taken(branch_taken),
    .target_pc(target_pc), .nullify_req(nullify_req), .imem_ready(imem_ready),
    .imem_req(imem_req), .fetch_addr(fetch_addr), .pc_front(pc_front),
    .pc_back(pc_back), .nullify_out(nullify_out), .redirect_pend(redirect_pend)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_live  = 0;
    m_front = 8'h00;
    m_back  = 8'h04;
    m_ptgt  = 0;
    m_pend  = 0;
    m_nul   = 0;
  endtask

  // One clock: rising edge updates the model from the same inputs the DUT saw.
  task automatic tick();
    @(posedge clk);
    if (!m_live) begin
      m_live = 1;
    end else if (imem_ready && !stall_in) begin
      m_front = m_back;
      if (branch_taken)   m_back = int'(target_pc);
      else if (m_pend)    m_back = m_ptgt;
      else                m_back = (m_back + 4) % 256;
      m_pend = 0;
      m_nul  = nullify_req;
    end else if (branch_taken) begin
      m_pend = 1;
      m_ptgt = int'(target_pc);
    end
    @(negedge clk);
    chk("model_front", 32'(pc_front), 32'(m_front));
    chk("model_back", 32'(pc_back), 32'(m_back));
    chk("model_fetch", 32'(fetch_addr), 32'(m_front));
    chk("model_req", 32'(imem_req), 32'(m_live));
    chk("model_nul", 32'(nullify_out), 32'(m_nul));
    chk("model_rp", 32'(redirect_pend), 32'(m_pend));
  endtask

  task automatic idle_inputs();
    stall_in = 0; branch_taken = 0; nullify_req = 0; imem_ready = 1; target_pc = 8'h00;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    #12;
    chk("rst_front", 32'(pc_front), 32'h00);
    chk("rst_back", 32'(pc_back), 32'h04);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_nul", 32'(nullify_out), 32'h0);
    chk("rst_rp", 32'(redirect_pend), 32'h0);
    @(negedge clk);
    rst_n = 1;

    // 1: boot cycle, then sequential fetch
    tick();
    chk("t1_boot_front", 32'(pc_front), 32'h00);
    chk("t1_req_on", 32'(imem_req), 32'h1);
    tick(); chk("t1_front04", 32'(pc_front), 32'h04);
    tick(); chk("t1_front08", 32'(pc_front), 32'h08);
    tick(); chk("t1_back10", 32'(pc_back), 32'h10);
    tick(); chk("t1_front10", 32'(pc_front), 32'h10);

    // 2: taken branch, delay slot then target
    branch_taken = 1; target_pc = 8'h40;
    tick();
    chk("t2_slot_front", 32'(pc_front), 32'h14);
    chk("t2_tgt_back", 32'(pc_back), 32'h40);
    branch_taken = 0;
    tick();
    chk("t2_tgt_front", 32'(pc_front), 32'h40);
    chk("t2_back44", 32'(pc_back), 32'h44);

    // 3: branch captured during a stall
    stall_in = 1; branch_taken = 1; target_pc = 8'h80;
    tick();
    chk("t3_hold_front", 32'(pc_front), 32'h40);
    chk("t3_rp_set", 32'(redirect_pend), 32'h1);
    branch_taken = 0; target_pc = 8'h11;
    tick(); tick();
    chk("t3_hold_back", 32'(pc_back), 32'h44);
    stall_in = 0;
    tick();
    chk("t3_back80", 32'(pc_back), 32'h80);
    chk("t3_rp_clr", 32'(redirect_pend), 32'h0);

    // 4: memory not ready for two cycles
    imem_ready = 0;
    tick(); tick();
    chk("t4_fetch_hold", 32'(fetch_addr), 32'h44);
    chk("t4_req_hold", 32'(imem_req), 32'h1);
    imem_ready = 1;
    tick();
    chk("t4_resume", 32'(pc_front), 32'h80);

    // 5: modulo wrap of the back PC
    branch_taken = 1; target_pc = 8'hF8;
    tick();
    branch_taken = 0;
    tick(); tick();
    chk("t5_front_fc", 32'(pc_front), 32'hFC);
    chk("t5_back_wrap", 32'(pc_back), 32'h00);

    // 6: nullify held across a stall, cleared on next advance
    nullify_req = 1;
    tick();
    chk("t6_nul_set", 32'(nullify_out), 32'h1);
    nullify_req = 0; stall_in = 1;
    tick(); tick();
    chk("t6_nul_held", 32'(nullify_out), 32'h1);
    stall_in = 0;
    tick();
    chk("t6_nul_clr", 32'(nullify_out), 32'h0);

    // 7: async reset while waiting with a pending redirect
    imem_ready = 0; branch_taken = 1; target_pc = 8'h33;
    tick();
    chk("t7_rp_before", 32'(redirect_pend), 32'h1);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk("t7_front", 32'(pc_front), 32'h00);
    chk("t7_back", 32'(pc_back), 32'h04);
    chk("t7_req", 32'(imem_req), 32'h0);
    chk("t7_rp", 32'(redirect_pend), 32'h0);
    chk("t7_nul", 32'(nullify_out), 32'h0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;

    // Randomized traffic against the model, including BOOT-time noise
    for (int i = 0; i < 400; i++) begin
      stall_in     = ($urandom_range(0, 3) == 0);
      imem_ready   = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      nullify_req  = ($urandom_range(0, 3) == 0);
      target_pc    = 8'($urandom_range(0, 63) * 4);
      if (i == 200) begin
        rst_n = 0;
        model_reset();
        #1;
        chk("rnd_rst_front", 32'(pc_front), 32'h00);
        @(negedge clk);
        rst_n = 1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
